gate_exerciser: RTL
===================

Name: gate_exerciser

Overview:
Sequential stimulus and response checker for a 2-input combinational gate under test, such as the team's delayed NAND cell.
- Drives the gate's two inputs through all four combinations.
- Waits a settle window, then samples the gate's output and compares it with a parameterised truth table.
- Reports per-vector failures and an overall pass flag, which can go directly to Mojo LEDs.

Parameters:
SETTLE_CYCLES, 4, clocks held per vector before sampling; must be >= 3 (2-flop sync plus gate delay); elaboration error otherwise
TRUTH, 4'b0111, expected gate output indexed by {drv_in1,drv_in2}; default = NAND

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a sweep; sampled only in IDLE or DONE
dut_out  input  1  output of gate under test; asynchronous to clk
drv_in1  output  1  gate input 1 (registered)
drv_in2  output  1  gate input 2 (registered)
busy  output  1  high while a sweep is in progress
done  output  1  sweep complete
pass  output  1  done & (fail_vec == 0)
fail_vec  output  4  bit i set = vector i mismatched

Behaviour:
- Interface decided: one clock clk; reset rst asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; vector index idx=0; settle counter=0; synchroniser flops=0.
- dut_out passes through a 2-flop synchroniser (dut_s) before any use.
- States and transitions:
  - IDLE: on start -> DRIVE; clear fail_vec and done.
  - DRIVE (1 cycle): register {drv_in1,drv_in2} <= idx; load counter = SETTLE_CYCLES-1; -> SETTLE.
  - SETTLE: decrement counter each cycle; at 0 -> SAMPLE. Drive outputs are held.
  - SAMPLE (1 cycle): fail_vec[idx] <= (dut_s != TRUTH[idx]). If idx==3 -> DONE, else idx <= idx+1 and -> DRIVE.
  - DONE: done=1 and drive outputs held at 2'b11. On start: clear fail_vec and done, set idx=0, -> DRIVE.
- busy = 1 in DRIVE, SETTLE and SAMPLE; 0 in IDLE and DONE.
- Latency:
  - Each vector takes SETTLE_CYCLES+2 clocks.
  - done rises 4*(SETTLE_CYCLES+2) clocks after the edge that samples start. Default: 24 clocks.
- start while busy: ignored; no restart and no state disturbance.
- start held high in DONE: a new sweep begins on every entry to DONE.
- idx is 2 bits. The increment never wraps inside a sweep because idx==3 exits to DONE.
- Reset asserted mid-sweep: immediate return to IDLE with all outputs 0. A partial fail_vec is discarded.
- pass is combinational from registered done and fail_vec (no added latency).

Optional Feature:
- Macro: GATE_EX_LOOP_EN
- Defined:
  - SAMPLE at idx==3 returns to DRIVE with idx=0 instead of entering DONE.
  - done becomes a one-cycle pulse per completed sweep.
  - fail_vec is sticky across sweeps; it is cleared only by rst.
  - busy stays 1 after the first start; start is ignored after the first sweep begins.
  - pass = (fail_vec == 0) sampled on each done pulse, then held.
- Undefined: single-sweep behaviour as above.

Decomposition:
- Shared header gate_ex_defs.vh holds:
  - state encodings: IDLE=0, DRIVE=1, SETTLE=2, SAMPLE=3, DONE=4 (3-bit);
  - truth-table constants TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110.
- One sub-module: sync2, a 2-flop synchroniser with asynchronous active-high reset. It is reused for dut_out.

Test Plan:
- Correct NAND DUT (2-clock delay model), SETTLE_CYCLES=4, pulse start -> drive sequence 00,01,10,11 each held 6 clocks; done=1 at clock 24; fail_vec=4'b0000; pass=1.
- DUT stuck-at-1 -> fail_vec=4'b1000, pass=0, done=1.
- DUT replaced by AND gate with TRUTH=TT_NAND -> fail_vec=4'b1111, pass=0.
- rst asserted during vector 2 SETTLE -> same cycle: busy=0, drv_in1/drv_in2=0, fail_vec=0; a subsequent start runs a clean 24-clock sweep.
- start pulsed at clocks 5 and 10 of a sweep -> ignored, done still at clock 24. start in DONE -> done drops next clock and a new sweep begins.
- GATE_EX_LOOP_EN, DUT glitching wrong on vector 1 only in sweep 2 -> done pulses at clocks 24, 48, 72; fail_vec=4'b0010 persists after sweep 3.

Source files
------------

// File: rtl/gate_exerciser_pkg.sv
// Shared types and constants for the gate exerciser: FSM state encoding, common
// truth tables and the per-vector compare helper.
package gate_exerciser_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDrive  = 3'd1,
    StSettle = 3'd2,
    StSample = 3'd3,
    StDone   = 3'd4
  } state_e;

  // Expected gate output indexed by {drv_in1, drv_in2}.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  function automatic logic vec_mismatch(logic [3:0] truth, logic [1:0] idx, logic sampled);
    return sampled != truth[idx];
  endfunction

endpackage

// File: rtl/gate_exerciser_sync2.sv
// Two-flop synchroniser with asynchronous active-high reset; used to bring the
// gate-under-test output into the clk domain.
module gate_exerciser_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps a 2-input gate through all four input combinations and checks each
// settled output against TRUTH. Define GATE_EX_LOOP_EN for continuous sweeping.
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  TRUTH         = TT_NAND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
);

  // Two synchroniser flops plus the gate's own delay need at least three clocks.
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 3");
  end

  localparam int unsigned   CntW    = $clog2(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  state_e          state_q;
  logic [1:0]      idx_q;
  logic [CntW-1:0] cnt_q;
  logic            dut_s;
  logic            mis;
  logic [3:0]      fail_upd;

  gate_exerciser_sync2 u_sync_dut (
    .clk (clk),
    .rst (rst),
    .d   (dut_out),
    .q   (dut_s)
  );

  assign mis      = vec_mismatch(TRUTH, idx_q, dut_s);
  assign fail_upd = fail_vec | (4'(mis) << idx_q);

`ifdef GATE_EX_LOOP_EN
  logic pass_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      drv_in1  <= 1'b0;
      drv_in2  <= 1'b0;
      done     <= 1'b0;
      fail_vec <= 4'b0;
      pass_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) state_q <= StDrive;
        end
        StDrive: begin
          {drv_in1, drv_in2} <= idx_q;
          cnt_q              <= CntLoad;
          state_q            <= StSettle;
        end
        StSettle: begin
          if (cnt_q == '0) state_q <= StSample;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        StSample: begin
          // Failures accumulate across sweeps; only rst clears them.
          fail_vec <= fail_upd;
          state_q  <= StDrive;
          if (idx_q == 2'd3) begin
            idx_q  <= 2'd0;
            done   <= 1'b1;
            pass_q <= (fail_upd == 4'b0);
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pass = pass_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      drv_in1  <= 1'b0;
      drv_in2  <= 1'b0;
      done     <= 1'b0;
      fail_vec <= 4'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            fail_vec <= 4'b0;
            done     <= 1'b0;
            state_q  <= StDrive;
          end
        end
        StDrive: begin
          {drv_in1, drv_in2} <= idx_q;
          cnt_q              <= CntLoad;
          state_q            <= StSettle;
        end
        StSettle: begin
          if (cnt_q == '0) state_q <= StSample;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        StSample: begin
          // fail_vec was cleared at sweep start, so OR-ing sets exactly bit idx.
          fail_vec <= fail_upd;
          if (idx_q == 2'd3) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= StDrive;
          end
        end
        StDone: begin
          if (start) begin
            fail_vec <= 4'b0;
            done     <= 1'b0;
            idx_q    <= 2'd0;
            state_q  <= StDrive;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pass = done & (fail_vec == 4'b0);
`endif

  assign busy = (state_q == StDrive) || (state_q == StSettle) || (state_q == StSample);

endmodule
